// File: rtl/seq_alu.sv
// Multi-cycle ALU: one-clock logic/arith/shift ops plus iterative Booth multiply and
// restoring divide writing {HI, LO}. Define SEQ_ALU_DIV_EN to build the divide engine.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Z,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_NEG = 4'b1000;
    localparam logic [3:0] OP_NOT = 4'b1010;
    localparam logic [3:0] OP_SHL = 4'b1100;
    localparam logic [3:0] OP_SHR = 4'b1101;
    localparam logic [3:0] OP_ROL = 4'b1110;
    localparam logic [3:0] OP_ROR = 4'b1111;

    localparam logic [SHW:0]   WIDTH_V   = (SHW+1)'(WIDTH);
    localparam logic [SHW-1:0] COUNT_TOP = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t             state_reg, state_next;
    logic [SHW-1:0]     count_reg, count_next;
    // acc is one bit wider than the operand so Booth can subtract -2^(WIDTH-1) safely
    logic [WIDTH:0]     acc_reg, acc_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic [WIDTH-1:0]   m_reg, m_next;
    logic               qm1_reg, qm1_next;
    logic [2*WIDTH-1:0] z_next;
    logic               done_next, err_next;

`ifdef SEQ_ALU_DIV_EN
    logic               is_div_reg, is_div_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;
`endif

    // Single-cycle datapath
    logic               shift_big;
    logic [SHW-1:0]     sh;
    logic [SHW:0]       sh_inv;
    logic [WIDTH-1:0]   lo_result;

    assign shift_big = |B[WIDTH-1:SHW];
    assign sh        = B[SHW-1:0];
    assign sh_inv    = WIDTH_V - {1'b0, sh};

    always_comb begin
        lo_result = '0;
        case (op)
            OP_ADD: lo_result = A + B;
            OP_SUB: lo_result = A - B;
            OP_AND: lo_result = A & B;
            OP_OR:  lo_result = A | B;
            OP_NEG: lo_result = -B;
            OP_NOT: lo_result = ~B;
            OP_SHL: lo_result = shift_big ? '0 : (A << sh);
            OP_SHR: lo_result = shift_big ? '0 : (A >> sh);
            // shifting by sh_inv = WIDTH when sh = 0 yields 0, so no special case
            OP_ROL: lo_result = (A << sh) | (A >> sh_inv);
            OP_ROR: lo_result = (A >> sh) | (A << sh_inv);
            default: lo_result = '0;
        endcase
    end

    // Booth step: add/subtract multiplicand based on {q[0], q-1}, then arithmetic shift
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] booth_sum;

    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        booth_sum = acc_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   booth_sum = acc_reg + m_ext;
            2'b10:   booth_sum = acc_reg - m_ext;
            default: booth_sum = acc_reg;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN
    assign abs_a     = A[WIDTH-1] ? -A : A;
    assign abs_b     = B[WIDTH-1] ? -B : B;
    assign div_shift = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, m_reg};
    assign quo_fixed = neg_q_reg ? -q_reg : q_reg;
    assign rem_fixed = neg_r_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
`endif

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
        q_next      = q_reg;
        m_next      = m_reg;
        qm1_next    = qm1_reg;
        z_next      = Z;
        done_next   = 1'b0;
        err_next    = err;
`ifdef SEQ_ALU_DIV_EN
        is_div_next = is_div_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT,
                        OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                            z_next    = {Z[2*WIDTH-1:WIDTH], lo_result};
                            err_next  = 1'b0;
                            done_next = 1'b1;
                        end
                        OP_MUL: begin
                            state_next  = MUL;
                            count_next  = COUNT_TOP;
                            acc_next    = '0;
                            q_next      = A;
                            qm1_next    = 1'b0;
                            m_next      = B;
`ifdef SEQ_ALU_DIV_EN
                            is_div_next = 1'b0;
`endif
                        end
`ifdef SEQ_ALU_DIV_EN
                        OP_DIV: begin
                            if (B == '0) begin
                                err_next  = 1'b1;
                                done_next = 1'b1;
                            end else begin
                                state_next  = DIV;
                                count_next  = COUNT_TOP;
                                acc_next    = '0;
                                q_next      = abs_a;
                                m_next      = abs_b;
                                is_div_next = 1'b1;
                                neg_q_next  = A[WIDTH-1] ^ B[WIDTH-1];
                                neg_r_next  = A[WIDTH-1];
                            end
                        end
`endif
                        default: begin
                            err_next  = 1'b1;
                            done_next = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                q_next   = {booth_sum[0], q_reg[WIDTH-1:1]};
                qm1_next = q_reg[0];
                if (count_reg == '0) begin
                    state_next = FIX;
                end else begin
                    count_next = count_reg - SHW'(1);
                end
            end
`ifdef SEQ_ALU_DIV_EN
            DIV: begin
                if (!div_trial[WIDTH]) begin
                    acc_next = div_trial;
                    q_next   = {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    acc_next = div_shift;
                    q_next   = {q_reg[WIDTH-2:0], 1'b0};
                end
                if (count_reg == '0) begin
                    state_next = FIX;
                end else begin
                    count_next = count_reg - SHW'(1);
                end
            end
`endif
            FIX: begin
`ifdef SEQ_ALU_DIV_EN
                if (is_div_reg) begin
                    z_next = {rem_fixed, quo_fixed};
                end else begin
                    z_next = {acc_reg[WIDTH-1:0], q_reg};
                end
`else
                z_next = {acc_reg[WIDTH-1:0], q_reg};
`endif
                err_next   = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            m_reg      <= '0;
            qm1_reg    <= 1'b0;
            Z          <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            q_reg      <= q_next;
            m_reg      <= m_next;
            qm1_reg    <= qm1_next;
            Z          <= z_next;
            done       <= done_next;
            err        <= err_next;
`ifdef SEQ_ALU_DIV_EN
            is_div_reg <= is_div_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
`endif
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the datapath ALU. Single-cycle logic, arithmetic and shift/rotate ops complete in one clock. Signed multiply and divide run as WIDTH-step iterative engines behind a start/busy/done handshake, writing a {HI, LO} result pair. It sits between the register file's A/B operand latches and the HI/LO/Z registers, and the control unit sequences it.

## Interface
- WIDTH, 32: operand width; power of two, ≥ 8.
- SHW, $clog2(WIDTH): rotate-amount bits (derived, do not override).

- clk  in  1  rising-edge clock.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- op  in  4  opcode, captured with start.
- A  in  WIDTH  signed operand, captured with start.
- B  in  WIDTH  signed operand, captured with start.
- Z  out  2*WIDTH  result register {HI, LO}.
- busy  out  1  iterative op in progress.
- done  out  1  one-cycle pulse: Z/err valid for the finished op.
- err  out  1  status of last op: divide by zero or illegal op.

## Operation
- Opcodes:
  - 0001 add
  - 0010 sub (A−B)
  - 0011 mul
  - 0101 div
  - 0110 and
  - 0111 or
  - 1000 neg (−B)
  - 1010 not (~B)
  - 1100 shl (A<<B)
  - 1101 shr logical (A>>B)
  - 1110 rol
  - 1111 ror
  - All others are illegal.
- Single-cycle ops write LO only; HI is retained. Add/sub/neg wrap modulo 2^WIDTH; no carry or overflow output.
- shl/shr take B as unsigned; B ≥ WIDTH gives 0. rol/ror use B[SHW-1:0].
- mul: full 2*WIDTH-bit signed product. HI = upper half, LO = lower half. Radix-2 Booth, one step per cycle.
- div: restoring divide on magnitudes, then sign fix.
  - LO = quotient, truncated toward zero.
  - HI = remainder, sign of dividend.
  - (−2^(WIDTH−1)) / (−1): LO = −2^(WIDTH−1), HI = 0, err=0.
- B=0 on div: Z unchanged, err=1, single-cycle completion.
- Illegal op: Z unchanged, err=1, single-cycle completion.
- err is updated on every completion: 0 on success. It holds until the next completion.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: start & single-cycle/illegal/div-by-zero → complete, stay IDLE. start & mul → MUL. start & div (B≠0) → DIV.
  - MUL: WIDTH steps (counter WIDTH−1 down to 0) → FIX.
  - DIV: WIDTH steps (counter WIDTH−1 down to 0) → FIX.
  - FIX: write Z, pulse done → IDLE.
- start while busy=1 is ignored, with no queueing.
- clr at any time, including mid-iteration, aborts the op. Outputs go to Z=0, busy=0, done=0, err=0. State goes to IDLE and the counter to 0.

## Timing
- Start accepted at edge N (busy=0, start=1).
- Single-cycle, illegal and div-by-zero ops:
  - Z/err updated at edge N.
  - done=1 during cycle N..N+1.
  - busy stays 0.
- mul/div:
  - busy=1 from edge N to edge N+WIDTH+1.
  - Z/err written at edge N+WIDTH+1, together with done=1 for that one cycle.
  - Latency is WIDTH+1 clocks.
- A new start may be presented in the same cycle done is high, because busy is already 0.
- Z changes only at completion edges; it is stable otherwise.
- Operands are captured internally, so A/B/op may change after acceptance.

## Configuration
- SEQ_ALU_DIV_EN defined: divide engine, DIV state and opcode 0101 behave as above.
- Undefined: no divider logic. 0101 is treated as illegal: single-cycle completion, err=1, Z unchanged. mul is unaffected.

## Test plan
- Reset, then add A=7, B=−3 → done pulse one cycle after start; Z[31:0]=4, HI unchanged (0), busy never high.
- mul A=−6, B=7, WIDTH=32 → busy for 33 cycles; Z=0xFFFFFFFF_FFFFFFD6 on done, err=0.
- div A=−17, B=5 (SEQ_ALU_DIV_EN) → LO=−3, HI=−2 after 33 cycles. div A=0x80000000, B=−1 → LO=0x80000000, HI=0. div B=0 → err=1, Z unchanged, done after 1 cycle.
- rol A=0x80000001, B=33 → LO=0x00000003. shl A=1, B=32 → LO=0. ror A=1, B=1 → LO=0x80000000.
- mul started, then start with add 5 cycles later → add ignored, mul result delivered. clr asserted at cycle 10 of a mul → Z=0, busy=0 immediately; next add completes normally.
- Build without SEQ_ALU_DIV_EN: op 0101 → err=1, done after 1 cycle, Z unchanged. Opcode 0000 → err=1 in both builds.
